intpol_lin_nch: RTL and testbench

- Parametrised successor of the fixed 2-channel, factor-4 interpolator datapath: N lockstep channels, runtime-selectable power-of-two interpolation factor, and a bypass mode.
- Per-channel sample stream enters a shared-control synchronous input FIFO.
- A sequencer pops samples and emits linearly interpolated outputs to a downstream FIFO, throttled by that FIFO's almost-full.
- Sits between the AIP interface and the downstream filter chain.

---
 rtl/intpol_lin_defs.sv | 27 ++
 rtl/intpol_sync_fifo.sv | 66 ++++++
 rtl/intpol_lin_nch.sv | 239 +++++++++++++++++++++++
 tb/tb_intpol_lin_nch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/intpol_lin_defs.sv
// Shared encodings for the N-channel linear interpolator:
// sequencer states, output source select and status bit positions.
package intpol_lin_defs;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_LOAD,
      ST_RUN,
      ST_TAIL,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      SEL_ACC,
      SEL_X0,
      SEL_HEAD
   } sel_t;

   localparam int STS_DONE   = 0;
   localparam int STS_BUSY   = 1;
   localparam int STS_EMPTY  = 2;
   localparam int STS_AFULL  = 3;
   localparam int STS_BYPASS = 4;
   localparam int STS_OVF    = 5;

endpackage

// File: rtl/intpol_sync_fifo.sv
// First-word-fall-through synchronous FIFO with almost-full
// flag and a strobe for pushes dropped while full.
module intpol_sync_fifo #(
   parameter int DATA_WIDTH = 24,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_MARGIN  = 2
) (
   input  logic                  clk,
   input  logic                  rst_a,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  empty_o,
   output logic                  afull_o,
   output logic                  ovf_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef logic [ADDR_WIDTH-1:0] ptr_t;
   typedef logic [ADDR_WIDTH:0]   cnt_t;

   localparam cnt_t AF_LVL = cnt_t'(DEPTH - AF_MARGIN);
   localparam cnt_t FULL_LVL = cnt_t'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   cnt_t cnt_q, cnt_d;
   logic full, push_ok, pop_ok;

   assign full    = (cnt_q == FULL_LVL);
   assign empty_o = (cnt_q == '0);
   assign afull_o = (cnt_q >= AF_LVL);
   assign data_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is still taken when a pop frees a slot
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full || pop_ok);
   assign ovf_o   = push_i && !push_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q + ptr_t'(push_ok);
      rd_ptr_d = rd_ptr_q + ptr_t'(pop_ok);
      cnt_d    = cnt_q + cnt_t'(push_ok) - cnt_t'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/intpol_lin_nch.sv
// N-channel lockstep linear interpolator with runtime power-of-two
// factor and bypass, fed from an input FIFO, throttled downstream.
module intpol_lin_nch
   import intpol_lin_defs::*;
#(
   parameter int NCH        = 2,
   parameter int W          = 12,
   parameter int LOG2_L_MAX = 3,
   parameter int FIFO_AW    = 3,
   parameter int AF_MARGIN  = 2,
   parameter int CNT_W      = 16
) (
   input  logic                            clk,
   input  logic                            rst_a,
   input  logic                            start,
   input  logic                            cfg_bypass,
   input  logic [$clog2(LOG2_L_MAX+1)-1:0] cfg_log2_l,
   input  logic [CNT_W-1:0]                cfg_num_samples,
   input  logic                            wr_en_i,
   input  logic [NCH*W-1:0]                data_i,
   output logic                            afull_o,
   output logic                            empty_o,
   input  logic                            afull_i,
   output logic                            wr_en_o,
   output logic [NCH*W-1:0]                data_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic [7:0]                      status_o
);

   localparam int SW = $clog2(LOG2_L_MAX + 1);
   localparam int AW = W + LOG2_L_MAX + 1;

   typedef logic [SW-1:0]         s_t;
   typedef logic [LOG2_L_MAX-1:0] k_t;
   typedef logic [CNT_W-1:0]      cnt_t;

   localparam cnt_t CNT_ONE = cnt_t'(1);

   state_t state_q, state_d;
   logic   bypass_q, bypass_d;
   s_t     s_q, s_d, s_cfg;
   cnt_t   rem_q, rem_d;
   k_t     k_q, k_d, k_last;
   logic   ovf_q, ovf_d;
   logic   wr_en_q, wr_en_d;
   logic   [NCH*W-1:0] data_q, data_d;

   logic   pop, ld_x0, ld_x1, step, adv, emit, clr_ovf;
   sel_t   sel;

   logic   [NCH*W-1:0] fifo_data;
   logic   fifo_ovf;
   logic   [NCH-1:0][W-1:0] emit_data;

   intpol_sync_fifo #(
      .DATA_WIDTH (NCH*W),
      .ADDR_WIDTH (FIFO_AW),
      .AF_MARGIN  (AF_MARGIN)
   ) u_fifo (
      .clk     (clk),
      .rst_a   (rst_a),
      .push_i  (wr_en_i),
      .data_i  (data_i),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .empty_o (empty_o),
      .afull_o (afull_o),
      .ovf_o   (fifo_ovf)
   );

   assign s_cfg  = (int'(cfg_log2_l) > LOG2_L_MAX) ?
                   s_t'(LOG2_L_MAX) : cfg_log2_l;
   assign k_last = k_t'((32'd1 << s_q) - 32'd1);

   always_comb begin
      state_d  = state_q;
      bypass_d = bypass_q;
      s_d      = s_q;
      rem_d    = rem_q;
      k_d      = k_q;
      pop      = 1'b0;
      ld_x0    = 1'b0;
      ld_x1    = 1'b0;
      step     = 1'b0;
      adv      = 1'b0;
      emit     = 1'b0;
      clr_ovf  = 1'b0;
      sel      = SEL_ACC;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               bypass_d = cfg_bypass;
               s_d      = s_cfg;
               rem_d    = cfg_num_samples;
               clr_ovf  = 1'b1;
               state_d  = (cfg_num_samples == '0) ? ST_DONE : ST_PRIME;
            end
         end
         ST_PRIME: begin
            // Bypass streams each popped sample straight out
            if (bypass_q) begin
               if (!empty_o && !afull_i) begin
                  pop   = 1'b1;
                  emit  = 1'b1;
                  sel   = SEL_HEAD;
                  rem_d = rem_q - CNT_ONE;
                  if (rem_q == CNT_ONE) state_d = ST_DONE;
               end
            end else if (!empty_o) begin
               pop     = 1'b1;
               ld_x0   = 1'b1;
               rem_d   = rem_q - CNT_ONE;
               state_d = (rem_q == CNT_ONE) ? ST_TAIL : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!empty_o) begin
               pop     = 1'b1;
               ld_x1   = 1'b1;
               k_d     = '0;
               rem_d   = rem_q - CNT_ONE;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!afull_i) begin
               emit = 1'b1;
               step = 1'b1;
               k_d  = k_q + k_t'(1);
               if (k_q == k_last) begin
                  adv     = 1'b1;
                  state_d = (rem_q != '0) ? ST_LOAD : ST_TAIL;
               end
            end
         end
         ST_TAIL: begin
            if (!afull_i) begin
               emit    = 1'b1;
               sel     = SEL_X0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ovf_d   = (clr_ovf ? 1'b0 : ovf_q) | fifo_ovf;
      wr_en_d = emit;
      data_d  = emit ? emit_data : data_q;
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic signed [W-1:0]  head, x0_q, x0_d, x1_q, x1_d;
      logic signed [W:0]    diff_q, diff_d;
      logic signed [AW-1:0] acc_q, acc_d, acc_sh;

      assign head   = fifo_data[c*W +: W];
      assign acc_sh = acc_q >>> s_q;

      always_comb begin
         x0_d   = x0_q;
         x1_d   = x1_q;
         diff_d = diff_q;
         acc_d  = acc_q;
         if (ld_x0) x0_d = head;
         if (ld_x1) begin
            x1_d   = head;
            diff_d = {head[W-1], head} - {x0_q[W-1], x0_q};
            acc_d  = {{(AW-W){x0_q[W-1]}}, x0_q} << s_q;
         end
         if (step) acc_d = acc_q + {{(AW-W-1){diff_q[W]}}, diff_q};
         if (adv) x0_d = x1_q;
      end

      always_comb begin
         emit_data[c] = acc_sh[W-1:0];
         unique case (sel)
            SEL_X0:   emit_data[c] = x0_q;
            SEL_HEAD: emit_data[c] = head;
            default:  emit_data[c] = acc_sh[W-1:0];
         endcase
      end

      always_ff @(posedge clk or negedge rst_a) begin
         if (!rst_a) begin
            x0_q   <= '0;
            x1_q   <= '0;
            diff_q <= '0;
            acc_q  <= '0;
         end else begin
            x0_q   <= x0_d;
            x1_q   <= x1_d;
            diff_q <= diff_d;
            acc_q  <= acc_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state_q  <= ST_IDLE;
         bypass_q <= 1'b0;
         s_q      <= '0;
         rem_q    <= '0;
         k_q      <= '0;
         ovf_q    <= 1'b0;
         wr_en_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         bypass_q <= bypass_d;
         s_q      <= s_d;
         rem_q    <= rem_d;
         k_q      <= k_d;
         ovf_q    <= ovf_d;
         wr_en_q  <= wr_en_d;
         data_q   <= data_d;
      end
   end

   assign wr_en_o = wr_en_q;
   assign data_o  = data_q;
   assign busy_o  = (state_q != ST_IDLE);
   assign done_o  = (state_q == ST_DONE);

   always_comb begin
      status_o             = '0;
      status_o[STS_DONE]   = done_o;
      status_o[STS_BUSY]   = busy_o;
      status_o[STS_EMPTY]  = empty_o;
      status_o[STS_AFULL]  = afull_i;
      status_o[STS_BYPASS] = bypass_q;
      status_o[STS_OVF]    = ovf_q;
   end

endmodule

// File: tb/tb_intpol_lin_nch.sv
// Directed bench for intpol_lin_nch: interpolation, floor rounding,
// stall, bypass, FIFO overflow and async reset.
module tb_intpol_lin_nch;

   localparam int NCH = 2;
   localparam int W   = 12;

   logic              clk = 1'b0;
   logic              rst_a = 1'b0;
   logic              start = 1'b0;
   logic              cfg_bypass = 1'b0;
   logic [1:0]        cfg_log2_l = '0;
   logic [15:0]       cfg_num_samples = '0;
   logic              wr_en_i = 1'b0;
   logic [NCH*W-1:0]  data_i = '0;
   logic              afull_o, empty_o;
   logic              afull_i = 1'b0;
   logic              wr_en_o;
   logic [NCH*W-1:0]  data_o;
   logic              busy_o, done_o;
   logic [7:0]        status_o;

   int n_vec = 0;
   int n_err = 0;
   int stall_wr;
   int nwr;
   int got0[$], got1[$], exp0[$], exp1[$];

   intpol_lin_nch #(
      .NCH(NCH), .W(W), .LOG2_L_MAX(3),
      .FIFO_AW(3), .AF_MARGIN(2), .CNT_W(16)
   ) dut (
      .clk             (clk),
      .rst_a           (rst_a),
      .start           (start),
      .cfg_bypass      (cfg_bypass),
      .cfg_log2_l      (cfg_log2_l),
      .cfg_num_samples (cfg_num_samples),
      .wr_en_i         (wr_en_i),
      .data_i          (data_i),
      .afull_o         (afull_o),
      .empty_o         (empty_o),
      .afull_i         (afull_i),
      .wr_en_o         (wr_en_o),
      .data_o          (data_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .status_o        (status_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   task automatic push(input int a, input int b);
      logic [31:0] va, vb;
      va = a;
      vb = b;
      @(posedge clk); #1;
      wr_en_i = 1'b1;
      data_i  = {vb[W-1:0], va[W-1:0]};
      @(posedge clk); #1;
      wr_en_i = 1'b0;
   endtask

   task automatic start_run(input int s, input int num, input bit byp);
      @(posedge clk); #1;
      cfg_log2_l      = 2'(s);
      cfg_num_samples = 16'(num);
      cfg_bypass      = byp;
      start           = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic collect(input int stall_at, input int stall_len,
                          output int n_at_done);
      bit done_seen;
      bit af_prev;
      got0.delete();
      got1.delete();
      stall_wr  = 0;
      af_prev   = 1'b0;
      done_seen = 1'b0;
      n_at_done = -1;
      for (int i = 0; i < 300 && !done_seen; i++) begin
         @(negedge clk);
         if (wr_en_o) begin
            got0.push_back(int'($signed(data_o[0 +: W])));
            got1.push_back(int'($signed(data_o[W +: W])));
            if (af_prev) stall_wr++;
         end
         if (done_o) begin
            done_seen = 1'b1;
            n_at_done = got0.size();
         end
         afull_i = (i >= stall_at) && (i < stall_at + stall_len);
         af_prev = afull_i;
      end
      afull_i = 1'b0;
      if (!done_seen) check("timeout_done", 0, 1);
   endtask

   task automatic cmp_out(input string tag);
      int n;
      check({tag, "_count"}, got0.size(), exp0.size());
      n = (got0.size() < exp0.size()) ? got0.size() : exp0.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_ch0_%0d", tag, i), got0[i], exp0[i]);
         check($sformatf("%s_ch1_%0d", tag, i), got1[i], exp1[i]);
      end
   endtask

   initial begin
      #1;
      check("rst_wr_en", int'(wr_en_o), 0);
      check("rst_data", int'(data_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_done", int'(done_o), 0);
      check("rst_empty", int'(empty_o), 1);
      check("rst_afull", int'(afull_o), 0);
      check("rst_status", int'(status_o), 4);
      @(negedge clk);
      rst_a = 1'b1;

      // s=2 ramp up on ch0, ramp down with floor on ch1
      push(0, 100);
      push(100, -4);
      start_run(2, 2, 1'b0);
      collect(1000, 0, nwr);
      exp0 = '{0, 25, 50, 75, 100};
      exp1 = '{100, 74, 48, 22, -4};
      cmp_out("interp");
      check("done_after_5th", nwr, 5);
      @(negedge clk);
      check("busy_low_after_done", int'(busy_o), 0);
      check("done_single", int'(done_o), 0);

      // 3-cycle stall after the first RUN output
      push(-8, 7);
      push(8, -9);
      start_run(2, 2, 1'b0);
      collect(3, 3, nwr);
      exp0 = '{-8, -4, 0, 4, 8};
      exp1 = '{7, 3, -1, -5, -9};
      cmp_out("stall");
      check("stall_no_write", stall_wr, 0);

      // bypass passes extremes unchanged
      push(5, -1);
      push(-7, 0);
      push(2047, 1);
      push(-2048, -2);
      start_run(2, 4, 1'b1);
      collect(1000, 0, nwr);
      exp0 = '{5, -7, 2047, -2048};
      exp1 = '{-1, 0, 1, -2};
      cmp_out("bypass");
      check("bypass_status4", int'(status_o[4]), 1);

      // 9 pushes into the 8-deep FIFO while idle
      for (int k = 1; k <= 9; k++) begin
         push(10 * k, -k);
         check($sformatf("afull_at_%0d", k), int'(afull_o),
               (k >= 6) ? 1 : 0);
      end
      check("ovf_sticky", int'(status_o[5]), 1);
      check("ovf_not_empty", int'(empty_o), 0);
      start_run(0, 8, 1'b1);
      check("ovf_cleared", int'(status_o[5]), 0);
      collect(1000, 0, nwr);
      exp0 = '{10, 20, 30, 40, 50, 60, 70, 80};
      exp1 = '{-1, -2, -3, -4, -5, -6, -7, -8};
      cmp_out("drain");
      check("drain_empty", int'(empty_o), 1);

      // async reset in the middle of RUN
      push(0, 0);
      push(80, -80);
      start_run(3, 2, 1'b0);
      repeat (5) @(negedge clk);
      check("pre_rst_writing", int'(wr_en_o), 1);
      #2;
      rst_a = 1'b0;
      #1;
      check("arst_wr_en", int'(wr_en_o), 0);
      check("arst_data", int'(data_o), 0);
      check("arst_busy", int'(busy_o), 0);
      check("arst_empty", int'(empty_o), 1);
      check("arst_status", int'(status_o), 4);
      @(negedge clk);
      rst_a = 1'b1;

      push(3, -3);
      push(9, -9);
      start_run(0, 2, 1'b0);
      collect(1000, 0, nwr);
      exp0 = '{3, 9};
      exp1 = '{-3, -9};
      cmp_out("post_rst");

      start_run(2, 0, 1'b0);
      collect(1000, 0, nwr);
      check("num0_writes", got0.size(), 0);
      check("num0_done_seen", nwr, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
